ama_riscv_hpm_counters: RTL and testbench
=========================================

Name: ama_riscv_hpm_counters

Overview:
Parametrised bank of RISC-V hardware performance monitor counters (mhpmcounterN/mhpmcounterNh, mhpmeventN, mcountinhibit) that extends the fixed mcycle/minstret CSR set. Each counter counts one or more events from the core's perf_event_t bundle, selected by a per-counter event mask. The block sits beside the core CSR file in the mem stage. The CSR file forwards accesses here on an address hit and muxes in csr_rdata.

Parameters:
NUM_CNT, 4, number of counters, legal range 1..29; counter i maps to architectural index 3+i
CNT_WIDTH, 64, counter width, legal range 33..64; read as low word plus zero-extended high word
NUM_EVT, 6, event bus width; equals the bit count of perf_event_t
CSR_CNT_BASE, 12'hB03, address of counter 0 low word
CSR_CNTH_BASE, 12'hB83, address of counter 0 high word
CSR_EVT_BASE, 12'h323, address of event select 0
CSR_INH, 12'h320, address of the inhibit register

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
csr_en  input  1  CSR access valid this cycle
csr_we  input  1  write enable, qualified by csr_en
csr_op  input  2  csr_op_t (NONE/RW/RS/RC)
csr_addr  input  12  CSR address
csr_wdata  input  32  write operand (rs1 or zero-extended uimm)
csr_rdata  output  32  read data, combinational
csr_hit  output  1  csr_addr decodes to a CSR implemented in this block
perf_evt  input  NUM_EVT  perf_event_t pulse bundle for this cycle
ovf  output  NUM_CNT  sticky overflow flags (see Optional Feature)

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: all counters 0; all event selects 0; inhibit 0; ovf 0.
- With no hit, csr_hit=0 and csr_rdata=0.
- Address decode: for i<NUM_CNT, a hit on CSR_CNT_BASE+i, CSR_CNTH_BASE+i, CSR_EVT_BASE+i, or CSR_INH. Addresses for indices >=NUM_CNT do not hit.
- Read:
  - csr_rdata reflects state before any same-cycle update, so read-modify-write is atomic.
  - Low access returns bits [31:0]; high access returns bits [CNT_WIDTH-1:32], zero-extended.
  - Event select reads NUM_EVT bits, zero-extended.
  - Inhibit reads the NUM_CNT bits at positions [3+NUM_CNT-1:3]; all other bits read 0.
- Write: occurs when csr_en & csr_we & hit & op!=NONE, applied at the next clk edge.
  - RW: new = wdata. RS: new = old | wdata. RC: new = old & ~wdata.
  - Bits outside the implemented width are ignored.
  - A low-word write changes only bits [31:0]; a high-word write changes only the upper bits.
- Increment: counter i increments by 1 when all of the following hold:
  - (evt_sel[i] & perf_evt) != 0
  - inhibit[3+i] == 0
  - no write targets counter i (either half) this cycle.
  - The increment is 1 even if several masked events fire in the same cycle.
- Priority: a CSR write to a counter wins; a coincident increment is dropped. A write to evt_sel or inhibit takes effect on the following cycle's increment decision.
- Wrap: when all CNT_WIDTH bits are 1 and an increment occurs, the counter wraps to 0.
- Latency: write visible on csr_rdata 1 cycle later; increment visible 1 cycle after the perf_evt pulse.
- Reset mid-operation: rst has priority over writes and increments in the same cycle.

Optional Feature:
Macro HPM_OVF_EN.
- Defined:
  - A wrap sets ovf[i], which is sticky.
  - An ovf register is readable at 12'hDA0, with bits at [3+NUM_CNT-1:3]. It hits only when the macro is defined.
  - The register is cleared by a RC/RW write to that address; RS sets are ignored.
  - A wrap coincident with a clearing write leaves the bit set.
- Not defined: ovf tied to 0; no overflow register; 12'hDA0 does not hit.

Decomposition:
- Into the shared types package:
  - csr_addr_t additions CSR_MHPMCOUNTER3, CSR_MHPMCOUNTER3H, CSR_MHPMEVENT3, CSR_MCOUNTINHIBIT, CSR_SCOUNTOVF
  - hpm_csr_kind_t enum (NONE/CNT_L/CNT_H/EVT/INH/OVF)
- Reuse csr_op_t and perf_event_t from the package.
- Sub-module ama_riscv_hpm_cnt: one counter plus its event select and ovf bit; generate NUM_CNT instances. Decode and read mux stay at the top level.

Test Plan:
- Reset: assert rst 2 cycles, then read B03/B83/323/320 -> all 0, csr_hit=1. Read B03+NUM_CNT -> csr_hit=0, rdata=0.
- Counting: write 323=6'b000100 (fe); pulse perf_evt.fe for 10 cycles with be simultaneously high -> B03 reads 10. Counter 1 (select 0) stays 0.
- Inhibit: write 320 RS with 32'h8 -> counter 0 frozen across 5 fe pulses; RC 32'h8 -> counting resumes, +1 per pulse.
- Write-vs-increment: write B03 RW 32'h100 in the same cycle as a fe pulse -> next read 32'h100, not 32'h101; B83 unchanged.
- Wrap: write B83=FFFF_FFFF and B03=FFFF_FFFF, one event -> both halves read 0. With HPM_OVF_EN, ovf[0]=1 and DA0 reads 32'h8; RC 32'h8 clears it.
- Atomic RS: counter at 32'h5, RS wdata 32'h2 -> rdata 32'h5 in that cycle, then 32'h7.

Source files
------------

// File: rtl/ama_riscv_hpm_counters_pkg.sv
// ----------------------------------------------------------------------------
// ama_riscv_hpm_counters_pkg
// Shared types for the hardware performance monitor counter bank. It provides
// the CSR opcode, the perf event bundle, the HPM CSR addresses, the decoded
// access kind, and a helper that turns a CSR op into set/clear bit masks.
// ----------------------------------------------------------------------------
package ama_riscv_hpm_counters_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_t;

    // Per-cycle event pulses from the core. Bit 0 is ret and bit 5 is dc_miss.
    typedef struct packed {
        logic dc_miss;
        logic ic_miss;
        logic br_miss;
        logic fe;
        logic be;
        logic ret;
    } perf_event_t;

    localparam int unsigned PERF_EVT_W = $bits(perf_event_t);

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MHPMEVENT3    = 12'h323,
        CSR_MHPMCOUNTER3  = 12'hB03,
        CSR_MHPMCOUNTER3H = 12'hB83,
        CSR_SCOUNTOVF     = 12'hDA0
    } csr_addr_t;

    typedef enum logic [2:0] {
        HPM_NONE,
        HPM_CNT_L,
        HPM_CNT_H,
        HPM_EVT,
        HPM_INH,
        HPM_OVF
    } hpm_csr_kind_t;

    // Every CSR op is expressed as new = (old & ~clr) | set. Registers of any
    // width can then share one decode by slicing the masks.
    typedef struct packed {
        logic [31:0] set;
        logic [31:0] clr;
    } csr_wmask_t;

    function automatic csr_wmask_t csr_wmask(input csr_op_t op, input logic [31:0] wdata);
        csr_wmask_t m;
        m.set = '0;
        m.clr = '0;
        case (op)
            CSR_OP_RW: begin
                m.set = wdata;
                m.clr = '1;
            end
            CSR_OP_RS: m.set = wdata;
            CSR_OP_RC: m.clr = wdata;
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ama_riscv_hpm_counters_if.sv
// ----------------------------------------------------------------------------
// ama_riscv_hpm_counters_if
// CSR access bus between the core CSR file (master) and the HPM bank (slave).
//   csr_en/csr_we/csr_op/csr_addr/csr_wdata : access request from the CSR file
//   csr_rdata/csr_hit                        : combinational read data and hit
// ----------------------------------------------------------------------------
interface ama_riscv_hpm_counters_if;
    import ama_riscv_hpm_counters_pkg::*;

    logic        csr_en;
    logic        csr_we;
    csr_op_t     csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;

    modport master (
        output csr_en, csr_we, csr_op, csr_addr, csr_wdata,
        input  csr_rdata, csr_hit
    );

    modport slave (
        input  csr_en, csr_we, csr_op, csr_addr, csr_wdata,
        output csr_rdata, csr_hit
    );

endinterface

// File: rtl/ama_riscv_hpm_counters_cnt.sv
// ----------------------------------------------------------------------------
// ama_riscv_hpm_cnt
// One HPM counter with its event select register and its overflow flag.
//   clk, rst         : clock, synchronous active-high reset
//   wr_lo_i/wr_hi_i  : CSR write to the low/high counter word this cycle
//   wr_evt_i         : CSR write to the event select this cycle
//   ovf_clr_i        : clear request for the overflow flag
//   wmask_i          : set/clear masks of the current CSR write
//   inhibit_i        : counting disabled
//   perf_evt_i       : event pulses
//   cnt_o, evt_sel_o : current counter and event select
//   ovf_o            : sticky overflow flag (HPM_OVF_EN only, else 0)
// ----------------------------------------------------------------------------
module ama_riscv_hpm_cnt
    import ama_riscv_hpm_counters_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned NUM_EVT   = PERF_EVT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic                 wr_evt_i,
    input  logic                 ovf_clr_i,
    input  csr_wmask_t           wmask_i,
    input  logic                 inhibit_i,
    input  logic [NUM_EVT-1:0]   perf_evt_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic [NUM_EVT-1:0]   evt_sel_o,
    output logic                 ovf_o
);

    localparam int unsigned HI_W = CNT_WIDTH - 32;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_EVT-1:0]   evt_q, evt_d;
    logic [CNT_WIDTH:0]   sum;
    logic                 inc;
    logic                 wrap;

    always_comb begin
        cnt_d = cnt_q;
        evt_d = evt_q;
        sum   = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
        // A write to either half of the counter drops a coincident increment.
        inc   = (|(evt_q & perf_evt_i)) && !inhibit_i && !wr_lo_i && !wr_hi_i;
        wrap  = inc && sum[CNT_WIDTH];

        if (wr_lo_i) begin
            cnt_d[31:0] = (cnt_q[31:0] & ~wmask_i.clr) | wmask_i.set;
        end
        if (wr_hi_i) begin
            cnt_d[CNT_WIDTH-1:32] = (cnt_q[CNT_WIDTH-1:32] & ~wmask_i.clr[HI_W-1:0])
                                  | wmask_i.set[HI_W-1:0];
        end
        if (inc) begin
            cnt_d = sum[CNT_WIDTH-1:0];
        end
        if (wr_evt_i) begin
            evt_d = (evt_q & ~wmask_i.clr[NUM_EVT-1:0]) | wmask_i.set[NUM_EVT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign evt_sel_o = evt_q;

`ifdef HPM_OVF_EN
    logic ovf_q, ovf_d;

    // Set beats clear, so a wrap in the same cycle as a clearing write is kept.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        if (wrap)      ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr_i ^ wrap;
    assign ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/ama_riscv_hpm_counters.sv
// ----------------------------------------------------------------------------
// ama_riscv_hpm_counters
// Bank of NUM_CNT RISC-V HPM counters (mhpmcounter3+i, mhpmcounter3+ih,
// mhpmevent3+i) with mcountinhibit. If HPM_OVF_EN is defined, the bank also
// has sticky overflow flags readable and clearable at scountovf (0xDA0).
//   clk, rst  : clock, synchronous active-high reset
//   csr       : CSR access bus (slave side); read data is combinational
//               and shows state before any update in the same cycle
//   perf_evt  : per-cycle event pulses
//   ovf       : sticky overflow flags (0 unless HPM_OVF_EN)
// ----------------------------------------------------------------------------
module ama_riscv_hpm_counters
    import ama_riscv_hpm_counters_pkg::*;
#(
    parameter int unsigned NUM_CNT       = 4,
    parameter int unsigned CNT_WIDTH     = 64,
    parameter int unsigned NUM_EVT       = PERF_EVT_W,
    parameter logic [11:0] CSR_CNT_BASE  = CSR_MHPMCOUNTER3,
    parameter logic [11:0] CSR_CNTH_BASE = CSR_MHPMCOUNTER3H,
    parameter logic [11:0] CSR_EVT_BASE  = CSR_MHPMEVENT3,
    parameter logic [11:0] CSR_INH       = CSR_MCOUNTINHIBIT
) (
    input  logic                          clk,
    input  logic                          rst,
    ama_riscv_hpm_counters_if.slave       csr,
    input  logic [NUM_EVT-1:0]            perf_evt,
    output logic [NUM_CNT-1:0]            ovf
);

    localparam int unsigned HI_W    = CNT_WIDTH - 32;
    localparam logic [11:0] CSR_OVF = CSR_SCOUNTOVF;

    hpm_csr_kind_t                         kind;
    logic [NUM_CNT-1:0]                    sel;
    logic                                  wr;
    csr_wmask_t                            wmask;
    logic [NUM_CNT-1:0]                    inh_q, inh_d;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0]     cnt_all;
    logic [NUM_CNT-1:0][NUM_EVT-1:0]       evt_all;
    logic [NUM_CNT-1:0]                    ovf_all;
    logic [31:0]                           rdata;

    // Address decode: kind tells which register family is addressed, and sel
    // is the one-hot counter index within that family.
    always_comb begin
        kind = HPM_NONE;
        sel  = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (csr.csr_addr == CSR_CNT_BASE + 12'(i)) begin
                kind   = HPM_CNT_L;
                sel[i] = 1'b1;
            end else if (csr.csr_addr == CSR_CNTH_BASE + 12'(i)) begin
                kind   = HPM_CNT_H;
                sel[i] = 1'b1;
            end else if (csr.csr_addr == CSR_EVT_BASE + 12'(i)) begin
                kind   = HPM_EVT;
                sel[i] = 1'b1;
            end
        end
        if (csr.csr_addr == CSR_INH) kind = HPM_INH;
`ifdef HPM_OVF_EN
        if (csr.csr_addr == CSR_OVF) kind = HPM_OVF;
`endif
    end

    assign wr    = csr.csr_en && csr.csr_we && (csr.csr_op != CSR_OP_NONE) && (kind != HPM_NONE);
    assign wmask = csr_wmask(csr.csr_op, csr.csr_wdata);

    always_comb begin
        inh_d = inh_q;
        if (wr && (kind == HPM_INH)) begin
            inh_d = (inh_q & ~wmask.clr[3 +: NUM_CNT]) | wmask.set[3 +: NUM_CNT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) inh_q <= '0;
        else     inh_q <= inh_d;
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        ama_riscv_hpm_cnt #(
            .CNT_WIDTH (CNT_WIDTH),
            .NUM_EVT   (NUM_EVT)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .wr_lo_i    (wr && (kind == HPM_CNT_L) && sel[g]),
            .wr_hi_i    (wr && (kind == HPM_CNT_H) && sel[g]),
            .wr_evt_i   (wr && (kind == HPM_EVT) && sel[g]),
            .ovf_clr_i  (wr && (kind == HPM_OVF) && wmask.clr[3+g]),
            .wmask_i    (wmask),
            .inhibit_i  (inh_q[g]),
            .perf_evt_i (perf_evt),
            .cnt_o      (cnt_all[g]),
            .evt_sel_o  (evt_all[g]),
            .ovf_o      (ovf_all[g])
        );
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (sel[i]) begin
                case (kind)
                    HPM_CNT_L: rdata              = cnt_all[i][31:0];
                    HPM_CNT_H: rdata[HI_W-1:0]    = cnt_all[i][CNT_WIDTH-1:32];
                    HPM_EVT:   rdata[NUM_EVT-1:0] = evt_all[i];
                    default: ;
                endcase
            end
        end
        if (kind == HPM_INH) rdata[3 +: NUM_CNT] = inh_q;
`ifdef HPM_OVF_EN
        if (kind == HPM_OVF) rdata[3 +: NUM_CNT] = ovf_all;
`endif
    end

    assign csr.csr_rdata = rdata;
    assign csr.csr_hit   = (kind != HPM_NONE);

`ifdef HPM_OVF_EN
    assign ovf = ovf_all;
`else
    logic unused_ovf;
    assign unused_ovf = ^ovf_all;
    assign ovf        = '0;
`endif

endmodule

// File: tb/tb_ama_riscv_hpm_counters.sv
// ----------------------------------------------------------------------------
// tb_ama_riscv_hpm_counters
// Directed bench for the HPM counter bank with default parameters. Each table
// record is one clock cycle of CSR bus and perf_evt stimulus, plus the
// read data and hit expected during that cycle. Expectations for the
// overflow register depend on HPM_OVF_EN.
// ----------------------------------------------------------------------------
module tb_ama_riscv_hpm_counters;
    import ama_riscv_hpm_counters_pkg::*;

    localparam logic [5:0] EV_NONE = 6'b000000;
    localparam logic [5:0] EV_RET  = 6'b000001;
    localparam logic [5:0] EV_FE   = 6'b000100;
    localparam logic [5:0] EV_FEBE = 6'b000110;
    localparam logic [5:0] EV_ALL  = 6'b111111;

`ifdef HPM_OVF_EN
    localparam logic        OVF_HIT = 1'b1;
    localparam logic [31:0] OVF_RD  = 32'h8;
    localparam logic [3:0]  OVF_C0  = 4'b0001;
`else
    localparam logic        OVF_HIT = 1'b0;
    localparam logic [31:0] OVF_RD  = 32'h0;
    localparam logic [3:0]  OVF_C0  = 4'b0000;
`endif

    typedef struct {
        logic        en;
        logic        we;
        csr_op_t     op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [5:0]  evt;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] perf_evt;
    logic [3:0] ovf;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[$];

    ama_riscv_hpm_counters_if bus ();

    ama_riscv_hpm_counters dut (
        .clk      (clk),
        .rst      (rst),
        .csr      (bus),
        .perf_evt (perf_evt),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic en, input logic we, input csr_op_t op,
                                input logic [11:0] addr, input logic [31:0] wdata,
                                input logic [5:0] evt, input logic hit, input logic [31:0] rd);
        vec_t v;
        v.en = en; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
        v.evt = evt; v.exp_hit = hit; v.exp_rd = rd;
        vecs.push_back(v);
    endfunction

    function automatic void rd_v(input logic [11:0] a, input logic [5:0] e,
                                 input logic h, input logic [31:0] x);
        add(1'b1, 1'b0, CSR_OP_NONE, a, 32'h0, e, h, x);
    endfunction

    function automatic void wr_v(input csr_op_t op, input logic [11:0] a, input logic [31:0] wd,
                                 input logic [5:0] e, input logic h, input logic [31:0] x);
        add(1'b1, 1'b1, op, a, wd, e, h, x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge. Drives one cycle and checks the
    // combinational outputs on the falling edge.
    task automatic apply(input vec_t v, input string tag);
        bus.csr_en    = v.en;
        bus.csr_we    = v.we;
        bus.csr_op    = v.op;
        bus.csr_addr  = v.addr;
        bus.csr_wdata = v.wdata;
        perf_evt      = v.evt;
        @(negedge clk);
        chk({tag, " hit"}, {31'h0, bus.csr_hit}, {31'h0, v.exp_hit});
        chk({tag, " rdata"}, bus.csr_rdata, v.exp_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.csr_en = 1'b0; bus.csr_we = 1'b0; bus.csr_op = CSR_OP_NONE;
        bus.csr_addr = 12'h000; bus.csr_wdata = 32'h0; perf_evt = EV_NONE;
    endtask

    vec_t hv;

    initial begin
        idle();
        // Reset state and decode boundaries
        rd_v(12'hB03, EV_NONE, 1'b1, 32'h0);
        rd_v(12'hB83, EV_NONE, 1'b1, 32'h0);
        rd_v(12'h323, EV_NONE, 1'b1, 32'h0);
        rd_v(12'h320, EV_NONE, 1'b1, 32'h0);
        rd_v(12'hB07, EV_NONE, 1'b0, 32'h0);
        rd_v(12'hB87, EV_NONE, 1'b0, 32'h0);
        rd_v(12'h327, EV_NONE, 1'b0, 32'h0);
        rd_v(12'hB02, EV_NONE, 1'b0, 32'h0);
        rd_v(12'hDA0, EV_NONE, OVF_HIT, 32'h0);
        // Counter 0 selects fe, and fe+be pulses count once per cycle
        wr_v(CSR_OP_RW, 12'h323, 32'h4, EV_NONE, 1'b1, 32'h0);
        rd_v(12'h323, EV_NONE, 1'b1, 32'h4);
        for (int k = 0; k < 10; k++) add(1'b0, 1'b0, CSR_OP_NONE, 12'hB03, 32'h0, EV_FEBE, 1'b1, 32'(k));
        rd_v(12'hB03, EV_NONE, 1'b1, 32'd10);
        rd_v(12'hB04, EV_NONE, 1'b1, 32'h0);
        // Inhibit takes effect one cycle after the write, in both directions
        wr_v(CSR_OP_RS, 12'h320, 32'h8, EV_FE, 1'b1, 32'h0);
        rd_v(12'h320, EV_FE, 1'b1, 32'h8);
        for (int k = 0; k < 4; k++) rd_v(12'hB03, EV_FE, 1'b1, 32'd11);
        wr_v(CSR_OP_RC, 12'h320, 32'h8, EV_FE, 1'b1, 32'h8);
        rd_v(12'hB03, EV_FE, 1'b1, 32'd11);
        rd_v(12'hB03, EV_FE, 1'b1, 32'd12);
        rd_v(12'hB03, EV_NONE, 1'b1, 32'd13);
        // A write beats a coincident increment
        wr_v(CSR_OP_RW, 12'hB03, 32'h100, EV_FE, 1'b1, 32'd13);
        rd_v(12'hB03, EV_NONE, 1'b1, 32'h100);
        rd_v(12'hB83, EV_NONE, 1'b1, 32'h0);
        // Read data is the old value during RS/RC (atomic read-modify-write)
        wr_v(CSR_OP_RW, 12'hB03, 32'h5, EV_NONE, 1'b1, 32'h100);
        wr_v(CSR_OP_RS, 12'hB03, 32'h2, EV_NONE, 1'b1, 32'h5);
        rd_v(12'hB03, EV_NONE, 1'b1, 32'h7);
        wr_v(CSR_OP_RC, 12'hB03, 32'h3, EV_NONE, 1'b1, 32'h7);
        rd_v(12'hB03, EV_NONE, 1'b1, 32'h4);
        // Full 64-bit wrap
        wr_v(CSR_OP_RW, 12'hB83, 32'hFFFF_FFFF, EV_NONE, 1'b1, 32'h0);
        wr_v(CSR_OP_RW, 12'hB03, 32'hFFFF_FFFF, EV_NONE, 1'b1, 32'h4);
        rd_v(12'hB83, EV_FE, 1'b1, 32'hFFFF_FFFF);
        rd_v(12'hB83, EV_NONE, 1'b1, 32'h0);
        rd_v(12'hB03, EV_NONE, 1'b1, 32'h0);
        rd_v(12'hDA0, EV_NONE, OVF_HIT, OVF_RD);
        wr_v(CSR_OP_RC, 12'hDA0, 32'h8, EV_NONE, OVF_HIT, OVF_RD);
        rd_v(12'hDA0, EV_NONE, OVF_HIT, 32'h0);
        // Last counter: the high word is independent of the low word
        wr_v(CSR_OP_RW, 12'hB86, 32'h1234_5678, EV_NONE, 1'b1, 32'h0);
        rd_v(12'hB86, EV_NONE, 1'b1, 32'h1234_5678);
        rd_v(12'hB06, EV_NONE, 1'b1, 32'h0);
        // Unimplemented bits of event select and inhibit read as zero
        wr_v(CSR_OP_RW, 12'h326, 32'hFFFF_FFFF, EV_NONE, 1'b1, 32'h0);
        rd_v(12'h326, EV_NONE, 1'b1, 32'h3F);
        wr_v(CSR_OP_RW, 12'h320, 32'hFFFF_FFFF, EV_NONE, 1'b1, 32'h0);
        rd_v(12'h320, EV_NONE, 1'b1, 32'h78);
        wr_v(CSR_OP_RW, 12'h320, 32'h0, EV_NONE, 1'b1, 32'h78);
        rd_v(12'h320, EV_NONE, 1'b1, 32'h0);
        // Several matching events in one cycle still add only 1
        rd_v(12'hB06, EV_RET, 1'b1, 32'h0);
        rd_v(12'hB06, EV_ALL, 1'b1, 32'h1);
        rd_v(12'hB06, EV_NONE, 1'b1, 32'h2);
        // No write without we, without en, or with op NONE
        add(1'b1, 1'b0, CSR_OP_RW,   12'hB06, 32'h99, EV_NONE, 1'b1, 32'h2);
        rd_v(12'hB06, EV_NONE, 1'b1, 32'h2);
        add(1'b0, 1'b1, CSR_OP_RW,   12'hB06, 32'h77, EV_NONE, 1'b1, 32'h2);
        rd_v(12'hB06, EV_NONE, 1'b1, 32'h2);
        add(1'b1, 1'b1, CSR_OP_NONE, 12'hB06, 32'h55, EV_NONE, 1'b1, 32'h2);
        rd_v(12'hB06, EV_NONE, 1'b1, 32'h2);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset ovf", {28'h0, ovf}, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // A wrap in the same cycle as a clearing write keeps the flag set
        wr_v(CSR_OP_RW, 12'hB83, 32'hFFFF_FFFF, EV_NONE, 1'b1, 32'h0);
        apply(vecs[vecs.size()-1], "seqA hi");
        wr_v(CSR_OP_RW, 12'hB03, 32'hFFFF_FFFF, EV_NONE, 1'b1, 32'h1);
        apply(vecs[vecs.size()-1], "seqA lo");
        wr_v(CSR_OP_RC, 12'hDA0, 32'h8, EV_FE, OVF_HIT, 32'h0);
        apply(vecs[vecs.size()-1], "seqA clr+wrap");
        chk("seqA ovf port", {28'h0, ovf}, {28'h0, OVF_C0});
        rd_v(12'hDA0, EV_NONE, OVF_HIT, OVF_RD);
        apply(vecs[vecs.size()-1], "seqA ovf kept");
        wr_v(CSR_OP_RC, 12'hDA0, 32'h8, EV_NONE, OVF_HIT, OVF_RD);
        apply(vecs[vecs.size()-1], "seqA clr");
        chk("seqA ovf cleared", {28'h0, ovf}, 32'h0);

        // Reset wins over a write and an increment in the same cycle
        wr_v(CSR_OP_RW, 12'hB03, 32'h77, EV_NONE, 1'b1, 32'h0);
        apply(vecs[vecs.size()-1], "seqB pre");
        rst = 1'b1;
        bus.csr_en = 1'b1; bus.csr_we = 1'b1; bus.csr_op = CSR_OP_RW;
        bus.csr_addr = 12'hB03; bus.csr_wdata = 32'h55; perf_evt = EV_FE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        hv.en = 1'b1; hv.we = 1'b0; hv.op = CSR_OP_NONE; hv.wdata = 32'h0;
        hv.evt = EV_NONE; hv.exp_hit = 1'b1; hv.exp_rd = 32'h0;
        hv.addr = 12'hB03; apply(hv, "seqB cnt");
        hv.addr = 12'h323; apply(hv, "seqB evt");
        hv.addr = 12'hB86; apply(hv, "seqB cnt3h");
        chk("seqB ovf", {28'h0, ovf}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
